conv1_window_gen: RTL and testbench
===================================

// Module: conv1_window_gen
// PURPOSE
//  Upstream feeder of the conv1 5x5 filter stage.
//  - Accepts a raster-order pixel stream (one pixel/cycle max, gaps allowed).
//  - Buffers FILTER_ROWS-1 image lines and emits every valid 5x5 window, flattened
//    row-major, directly onto the filter's 25-pixel input bus.
//  - Produces (IMG_HEIGHT-4)x(IMG_WIDTH-4) windows per frame (28x28 for LeNet 32x32).
// PARAMETERS
//  IMG_WIDTH    32  pixels per line
//  IMG_HEIGHT   32  lines per frame
//  FILTER_ROWS  5   window edge (square window, FILTER_ROWS x FILTER_ROWS)
//  PIXEL_WIDTH  8   bits per pixel
//  NUM_PIXELS   25  FILTER_ROWS*FILTER_ROWS; output vector length
// PORTS
//  conv1_win_clk     in   1                        single clock, rising edge
//  conv1_win_rst_b   in   1                        asynchronous active-low reset
//  pxl_valid_i       in   1                        pxl_data_i valid this cycle
//  pxl_sof_i         in   1                        first pixel of frame; qualified by pxl_valid_i
//  pxl_data_i        in   PIXEL_WIDTH              input pixel, raster order
//  pxl_win_vals_o    out  NUM_PIXELS x PIXEL_WIDTH window; index 5*r+c, r=0 top, c=0 left
//  win_valid_o       out  1                        pxl_win_vals_o holds a complete new window
//  win_last_o        out  1                        with win_valid_o: last window of frame
//  frame_err_o       out  1                        sticky: SOF arrived before frame completed
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - all outputs 0; col/row counters 0; window regs 0.
//  - Line-buffer RAM contents are don't-care (never observed before refill).
//  Accept:
//  - A pixel is accepted when pxl_valid_i=1. No backpressure (the filter stage never stalls).
//  - pxl_valid_i=0: counters, line buffers and window regs hold; win_valid_o=0 next cycle.
//  Counters:
//  - col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance per accepted pixel.
//  - col wraps to 0 and increments row; after (H-1,W-1) both wrap to 0.
//  SOF:
//  - Accepted pixel with pxl_sof_i=1 is treated as (0,0) regardless of counters.
//  - If the counters were not at (0,0), set frame_err_o (cleared only by reset).
//  - SOF on a non-accepted cycle is ignored.
//  Window:
//  - On accepting pixel (row,col), column shift: each window row r shifts left by one.
//  - New rightmost column = {line_buf[3..0] outputs at col, pxl_data_i}, i.e. pixels
//    (row-4..row, col).
//  Output timing:
//  - Latency 1: the cycle after accepting (row,col) with row>=4 and col>=4,
//    win_valid_o=1 and pxl_win_vals_o = pixels rows row-4..row x cols col-4..col.
//  - Element [5*r+c] = pixel(row-4+r, col-4+c).
//  - win_last_o=1 together with win_valid_o iff (row,col)=(H-1,W-1).
//  - win_valid_o, win_last_o are single-cycle per accepted pixel.
//  - pxl_win_vals_o holds its last value when win_valid_o=0.
//  Line edges:
//  - Cols 0..3 of every line shift in, but windows spanning a line wrap are never
//    flagged valid.
//  - Rows 0..3 only fill the line buffers.
//  Line buffers:
//  - FILTER_ROWS-1 chained delays of exactly IMG_WIDTH accepted pixels each.
//  - Buffer k outputs pixel (row-1-k, col); writes occur only on accept.
//  Simultaneous / abort:
//  - SOF coincident with what would be the last pixel: treated as new (0,0);
//    no win_last_o; frame_err_o set.
//  - Reset mid-frame: everything returns to reset values; next frame must start with SOF.
//  Arithmetic: no arithmetic on pixel data; counters $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT) bits.
// STRUCTURE
//  Package conv1_pkg:
//  - IMG_WIDTH, IMG_HEIGHT, FILTER_ROWS, PIXEL_WIDTH constants.
//  - typedef pixel_t [PIXEL_WIDTH-1:0].
//  - typedef win_t pixel_t [NUM_PIXELS-1:0], shared with conv1_compute_filter.
//  Sub-module conv1_line_buffer:
//  - One line delay, IMG_WIDTH x PIXEL_WIDTH, enable-gated.
//  - Single RAM with wrapping read/write pointer (read-before-write at the same
//    address), or shift regs.
//  - Instantiated FILTER_ROWS-1 times in a generate loop.
// TESTING
//  Let pixel(r,c) = (32*r + c) mod 256 for every test below.
//  T1 Full frame, continuous valid, pixel(r,c) as above:
//     - first win_valid_o one cycle after pixel #132 (4,4), with [0]=0, [4]=4,
//       [20]=128, [24]=132;
//     - exactly 784 valid windows; win_last_o only on the last, [24]=pixel(31,31)=255.
//  T2 Same frame, pxl_valid_i toggling 1/0 randomly (50%):
//     - identical window sequence to T1; win_valid_o never asserted on idle-following cycles.
//  T3 Line wrap:
//     - no valid window after accepting cols 0..3 of any row >=4;
//     - window after (5,4) has [0]=pixel(1,0)=32.
//  T4 Mid-frame SOF at (10,7):
//     - frame_err_o=1 next cycle; restarts at (0,0);
//     - next valid window only after new (4,4), contents from new frame only.
//  T5 Async reset asserted mid-frame (row 12), then new frame:
//     - outputs 0 immediately on assert;
//     - post-reset behaviour identical to T1; frame_err_o=0.
//  T6 Back-to-back frames with SOF on each first pixel:
//     - 784 windows per frame, 2 win_last_o pulses, frame_err_o stays 0.

Source files
------------

// File: rtl/conv1_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package : conv1_pkg
// Shared geometry constants and pixel/window types for the conv1 stage.
// Rev 1.0 : initial release
// ============================================================================
package conv1_pkg;

    localparam int IMG_WIDTH   = 32;
    localparam int IMG_HEIGHT  = 32;
    localparam int FILTER_ROWS = 5;
    localparam int PIXEL_WIDTH = 8;
    localparam int NUM_PIXELS  = FILTER_ROWS * FILTER_ROWS;
    localparam int COL_W       = $clog2(IMG_WIDTH);
    localparam int ROW_W       = $clog2(IMG_HEIGHT);

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t [NUM_PIXELS-1:0] win_t;

endpackage
`default_nettype wire

// File: rtl/conv1_window_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : conv1_window_gen_if
// Pixel stream in, flattened 5x5 window out, between source and window gen.
// Rev 1.0 : initial release
// ============================================================================
interface conv1_window_gen_if;
    import conv1_pkg::*;

    logic   pxl_valid_i;
    logic   pxl_sof_i;
    pixel_t pxl_data_i;
    win_t   pxl_win_vals_o;
    logic   win_valid_o;
    logic   win_last_o;
    logic   frame_err_o;

    modport master (
        output pxl_valid_i, pxl_sof_i, pxl_data_i,
        input  pxl_win_vals_o, win_valid_o, win_last_o, frame_err_o
    );

    modport slave (
        input  pxl_valid_i, pxl_sof_i, pxl_data_i,
        output pxl_win_vals_o, win_valid_o, win_last_o, frame_err_o
    );

endinterface
`default_nettype wire

// File: rtl/conv1_window_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : conv1_line_buffer
// One image-line delay: RAM with a wrapping pointer, read-before-write.
// Rev 1.0 : initial release
// ============================================================================
module conv1_line_buffer
    import conv1_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    input  pixel_t    din,
    output pixel_t    dout
);

    pixel_t           mem [IMG_WIDTH];
    logic [COL_W-1:0] r_ptr;

    // Output is the pixel written exactly IMG_WIDTH enables ago.
    assign dout = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[r_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == COL_W'(IMG_WIDTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv1_window_gen.sv
`default_nettype none
// ============================================================================
// Module  : conv1_window_gen
// Raster pixel stream to sliding 5x5 window generator feeding the conv1 filter.
// Rev 1.0 : initial release
// ============================================================================
module conv1_window_gen
    import conv1_pkg::*;
(
    input  wire logic         conv1_win_clk,
    input  wire logic         conv1_win_rst_b,
    conv1_window_gen_if.slave bus
);

    localparam int NUM_LB = FILTER_ROWS - 1;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_accept;
    logic             w_sof;
    logic             w_at_origin;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_win_ok;
    win_t             r_win;
    win_t             w_win_next;
    win_t             r_out;
    logic             r_valid;
    logic             r_last;
    logic             r_err;
    pixel_t           w_lb_in  [NUM_LB];
    pixel_t           w_lb_out [NUM_LB];

    assign w_accept    = bus.pxl_valid_i;
    assign w_sof       = bus.pxl_valid_i & bus.pxl_sof_i;
    assign w_at_origin = (r_col == '0) && (r_row == '0);

    // SOF forces the accepted pixel to (0,0) whatever the counters say.
    assign w_col     = w_sof ? '0 : r_col;
    assign w_row     = w_sof ? '0 : r_row;
    assign w_col_end = (w_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_end = (w_row == ROW_W'(IMG_HEIGHT - 1));
    assign w_win_ok  = (w_row >= ROW_W'(FILTER_ROWS - 1)) && (w_col >= COL_W'(FILTER_ROWS - 1));

    generate
        for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
            if (k == 0) begin : g_head
                assign w_lb_in[k] = bus.pxl_data_i;
            end else begin : g_chain
                assign w_lb_in[k] = w_lb_out[k-1];
            end
            conv1_line_buffer u_lb (
                .clk   (conv1_win_clk),
                .rst_n (conv1_win_rst_b),
                .en    (w_accept),
                .din   (w_lb_in[k]),
                .dout  (w_lb_out[k])
            );
        end
    endgenerate

    // Shift every window row left; the new right column is buffer k feeding row NUM_LB-1-k.
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < FILTER_ROWS; r++) begin
            for (int c = 0; c < FILTER_ROWS - 1; c++) begin
                w_win_next[r*FILTER_ROWS + c] = r_win[r*FILTER_ROWS + c + 1];
            end
            if (r == FILTER_ROWS - 1) begin
                w_win_next[r*FILTER_ROWS + FILTER_ROWS - 1] = bus.pxl_data_i;
            end else begin
                w_win_next[r*FILTER_ROWS + FILTER_ROWS - 1] = w_lb_out[NUM_LB - 1 - r];
            end
        end
    end

    always_ff @(posedge conv1_win_clk or negedge conv1_win_rst_b) begin
        if (!conv1_win_rst_b) begin
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_accept && w_win_ok;
            r_last  <= w_accept && w_win_ok && w_row_end && w_col_end;
            if (w_accept) begin
                r_win <= w_win_next;
                if (w_win_ok) begin
                    r_out <= w_win_next;
                end
                if (w_sof && !w_at_origin) begin
                    r_err <= 1'b1;
                end
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
        end
    end

    assign bus.pxl_win_vals_o = r_out;
    assign bus.win_valid_o    = r_valid;
    assign bus.win_last_o     = r_last;
    assign bus.frame_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv1_window_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv1_window_gen
// Self-checking bench: image-array reference model versus conv1_window_gen.
// Rev 1.0 : initial release
// ============================================================================
module tb_conv1_window_gen;
    import conv1_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv1_window_gen_if bus ();

    conv1_window_gen dut (
        .conv1_win_clk   (clk),
        .conv1_win_rst_b (rst_n),
        .bus             (bus)
    );

    int     tests = 0;
    int     fails = 0;
    pixel_t img [IMG_HEIGHT][IMG_WIDTH];
    int     mr, mc, last_r, last_c;
    logic   ev, el, ee;
    win_t   ew;

    function automatic pixel_t pix(input int r, input int c);
        return pixel_t'((32 * r + c) % 256);
    endfunction

    task automatic model_reset();
        mr = 0; mc = 0; ev = 0; el = 0; ee = 0; ew = '0;
    endtask

    // Drive one cycle, then advance the image-level model by the accepted pixel.
    task automatic drive(input logic v, input logic s, input pixel_t d);
        bus.pxl_valid_i = v;
        bus.pxl_sof_i   = s;
        bus.pxl_data_i  = d;
        @(posedge clk);
        #1;
        ev = 0;
        el = 0;
        if (v) begin
            if (s) begin
                if (mr != 0 || mc != 0) ee = 1;
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = d;
            last_r = mr;
            last_c = mc;
            if (mr >= FILTER_ROWS - 1 && mc >= FILTER_ROWS - 1) begin
                ev = 1;
                el = (mr == IMG_HEIGHT - 1) && (mc == IMG_WIDTH - 1);
                for (int r = 0; r < FILTER_ROWS; r++)
                    for (int c = 0; c < FILTER_ROWS; c++)
                        ew[r*FILTER_ROWS + c] = img[mr - (FILTER_ROWS-1) + r][mc - (FILTER_ROWS-1) + c];
            end
            mc++;
            if (mc == IMG_WIDTH) begin
                mc = 0;
                mr++;
                if (mr == IMG_HEIGHT) mr = 0;
            end
        end
    endtask

    task automatic test_reset();
        bus.pxl_valid_i = 0; bus.pxl_sof_i = 0; bus.pxl_data_i = '0;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.win_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.win_valid_o); end
        tests++; if (bus.win_last_o !== 1'b0) begin fails++; $display("FAIL reset_last got %b exp 0", bus.win_last_o); end
        tests++; if (bus.frame_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", bus.frame_err_o); end
        tests++; if (bus.pxl_win_vals_o !== '0) begin fails++; $display("FAIL reset_win got %h exp 0", bus.pxl_win_vals_o); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_full_frame();
        int nwin = 0, nlast = 0, nacc = 0;
        for (int i = 0; i < IMG_WIDTH * IMG_HEIGHT; i++) begin
            drive(1, i == 0, pix(i / IMG_WIDTH, i % IMG_WIDTH));
            nacc++;
            tests++;
            if (bus.win_valid_o !== ev || bus.win_last_o !== el || bus.frame_err_o !== ee || bus.pxl_win_vals_o !== ew) begin
                fails++;
                $display("FAIL full_cycle at (%0d,%0d) got v=%b l=%b e=%b w=%h exp v=%b l=%b e=%b w=%h",
                         last_r, last_c, bus.win_valid_o, bus.win_last_o, bus.frame_err_o, bus.pxl_win_vals_o, ev, el, ee, ew);
            end
            if (bus.win_valid_o === 1'b1 && nwin == 0) begin
                tests++;
                if (nacc != 133 || bus.pxl_win_vals_o[0] !== 8'd0 || bus.pxl_win_vals_o[4] !== 8'd4 ||
                    bus.pxl_win_vals_o[20] !== 8'd128 || bus.pxl_win_vals_o[24] !== 8'd132) begin
                    fails++;
                    $display("FAIL first_window got acc=%0d [0]=%0d [4]=%0d [20]=%0d [24]=%0d exp acc=133 0 4 128 132",
                             nacc, bus.pxl_win_vals_o[0], bus.pxl_win_vals_o[4], bus.pxl_win_vals_o[20], bus.pxl_win_vals_o[24]);
                end
            end
            if (bus.win_last_o === 1'b1) begin
                tests++;
                if (bus.pxl_win_vals_o[24] !== 8'd255) begin
                    fails++; $display("FAIL last_window_px got %0d exp 255", bus.pxl_win_vals_o[24]);
                end
            end
            if (bus.win_valid_o === 1'b1) nwin++;
            if (bus.win_last_o === 1'b1) nlast++;
        end
        tests++; if (nwin != 784) begin fails++; $display("FAIL full_count got %0d exp 784", nwin); end
        tests++; if (nlast != 1) begin fails++; $display("FAIL full_last_count got %0d exp 1", nlast); end
    endtask

    task automatic test_gaps();
        int acc = 0, nwin = 0;
        while (acc < IMG_WIDTH * IMG_HEIGHT) begin
            logic v;
            v = 1'($urandom_range(1, 0));
            drive(v, v && acc == 0, v ? pix(acc / IMG_WIDTH, acc % IMG_WIDTH) : pixel_t'($urandom));
            tests++;
            if (bus.win_valid_o !== ev || bus.win_last_o !== el || bus.frame_err_o !== ee || bus.pxl_win_vals_o !== ew) begin
                fails++;
                $display("FAIL gaps_cycle v_in=%b at (%0d,%0d) got v=%b l=%b e=%b w=%h exp v=%b l=%b e=%b w=%h",
                         v, last_r, last_c, bus.win_valid_o, bus.win_last_o, bus.frame_err_o, bus.pxl_win_vals_o, ev, el, ee, ew);
            end
            if (bus.win_valid_o === 1'b1) nwin++;
            if (v) acc++;
        end
        tests++; if (nwin != 784) begin fails++; $display("FAIL gaps_count got %0d exp 784", nwin); end
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < IMG_WIDTH * IMG_HEIGHT; i++) begin
            drive(1, i == 0, pix(i / IMG_WIDTH, i % IMG_WIDTH));
            if (last_c < FILTER_ROWS - 1) begin
                tests++;
                if (bus.win_valid_o !== 1'b0) begin
                    fails++; $display("FAIL wrap_no_valid at (%0d,%0d) got %b exp 0", last_r, last_c, bus.win_valid_o);
                end
            end
            if (last_r == 5 && last_c == 4) begin
                tests++;
                if (bus.win_valid_o !== 1'b1 || bus.pxl_win_vals_o[0] !== 8'd32) begin
                    fails++; $display("FAIL wrap_5_4 got v=%b [0]=%0d exp v=1 [0]=32", bus.win_valid_o, bus.pxl_win_vals_o[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int nwin = 0, nlast = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < IMG_WIDTH * IMG_HEIGHT; i++) begin
                drive(1, i == 0, (f == 0) ? pix(i / IMG_WIDTH, i % IMG_WIDTH) : pixel_t'($urandom));
                tests++;
                if (bus.win_valid_o !== ev || bus.win_last_o !== el || bus.frame_err_o !== ee || bus.pxl_win_vals_o !== ew) begin
                    fails++;
                    $display("FAIL b2b_cycle f=%0d at (%0d,%0d) got v=%b l=%b e=%b w=%h exp v=%b l=%b e=%b w=%h",
                             f, last_r, last_c, bus.win_valid_o, bus.win_last_o, bus.frame_err_o, bus.pxl_win_vals_o, ev, el, ee, ew);
                end
                if (bus.win_valid_o === 1'b1) nwin++;
                if (bus.win_last_o === 1'b1) nlast++;
            end
        end
        tests++; if (nwin != 1568) begin fails++; $display("FAIL b2b_count got %0d exp 1568", nwin); end
        tests++; if (nlast != 2) begin fails++; $display("FAIL b2b_last_count got %0d exp 2", nlast); end
        tests++; if (bus.frame_err_o !== 1'b0) begin fails++; $display("FAIL b2b_err got %b exp 0", bus.frame_err_o); end
    endtask

    task automatic test_mid_sof();
        int nwin = 0, nlast = 0;
        for (int i = 0; i < 10 * IMG_WIDTH + 7; i++) begin
            drive(1, i == 0, pixel_t'($urandom));
        end
        drive(1, 1, pix(0, 0));
        tests++;
        if (bus.frame_err_o !== 1'b1 || bus.win_valid_o !== 1'b0 || bus.win_last_o !== 1'b0) begin
            fails++; $display("FAIL midsof_err got e=%b v=%b l=%b exp e=1 v=0 l=0", bus.frame_err_o, bus.win_valid_o, bus.win_last_o);
        end
        for (int i = 1; i < IMG_WIDTH * IMG_HEIGHT; i++) begin
            drive(1, 0, pix(i / IMG_WIDTH, i % IMG_WIDTH));
            tests++;
            if (bus.win_valid_o !== ev || bus.win_last_o !== el || bus.frame_err_o !== ee || bus.pxl_win_vals_o !== ew) begin
                fails++;
                $display("FAIL midsof_cycle at (%0d,%0d) got v=%b l=%b e=%b w=%h exp v=%b l=%b e=%b w=%h",
                         last_r, last_c, bus.win_valid_o, bus.win_last_o, bus.frame_err_o, bus.pxl_win_vals_o, ev, el, ee, ew);
            end
            if (bus.win_valid_o === 1'b1) nwin++;
            if (bus.win_last_o === 1'b1) nlast++;
        end
        tests++; if (nwin != 784) begin fails++; $display("FAIL midsof_count got %0d exp 784", nwin); end
        tests++; if (nlast != 1) begin fails++; $display("FAIL midsof_last_count got %0d exp 1", nlast); end
    endtask

    task automatic test_reset_mid();
        int nwin = 0;
        for (int i = 0; i < 12 * IMG_WIDTH + 5; i++) begin
            drive(1, i == 0, pix(i / IMG_WIDTH, i % IMG_WIDTH));
        end
        bus.pxl_valid_i = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        tests++; if (bus.win_valid_o !== 1'b0) begin fails++; $display("FAIL arst_valid got %b exp 0", bus.win_valid_o); end
        tests++; if (bus.win_last_o !== 1'b0) begin fails++; $display("FAIL arst_last got %b exp 0", bus.win_last_o); end
        tests++; if (bus.frame_err_o !== 1'b0) begin fails++; $display("FAIL arst_err got %b exp 0", bus.frame_err_o); end
        tests++; if (bus.pxl_win_vals_o !== '0) begin fails++; $display("FAIL arst_win got %h exp 0", bus.pxl_win_vals_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < IMG_WIDTH * IMG_HEIGHT; i++) begin
            drive(1, i == 0, pix(i / IMG_WIDTH, i % IMG_WIDTH));
            tests++;
            if (bus.win_valid_o !== ev || bus.win_last_o !== el || bus.frame_err_o !== ee || bus.pxl_win_vals_o !== ew) begin
                fails++;
                $display("FAIL arst_cycle at (%0d,%0d) got v=%b l=%b e=%b w=%h exp v=%b l=%b e=%b w=%h",
                         last_r, last_c, bus.win_valid_o, bus.win_last_o, bus.frame_err_o, bus.pxl_win_vals_o, ev, el, ee, ew);
            end
            if (bus.win_valid_o === 1'b1) nwin++;
        end
        tests++; if (nwin != 784) begin fails++; $display("FAIL arst_count got %0d exp 784", nwin); end
        tests++; if (bus.frame_err_o !== 1'b0) begin fails++; $display("FAIL arst_err_after got %b exp 0", bus.frame_err_o); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_line_wrap();
        test_back_to_back();
        test_mid_sof();
        test_reset_mid();
        bus.pxl_valid_i = 0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
